// File: rtl/argmax_row_ctrl.sv
// Row-wise fp16 argmax sequencer: streams each row out of a 1-cycle-latency SRAM,
// keeps the running max and its column, and hands one result per row over valid/ready.
module argmax_row_ctrl #(
  parameter int unsigned ADDR_WIDTH  = 16,
  parameter int unsigned INDEX_WIDTH = 16,
  parameter int unsigned ROW_WIDTH   = 16,
  parameter int unsigned DATA_WIDTH  = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [ADDR_WIDTH-1:0]  cfg_base_addr,
  input  logic [ROW_WIDTH-1:0]   cfg_num_rows,
  input  logic [INDEX_WIDTH-1:0] cfg_row_len,
  output logic                   busy,
  output logic                   done,
  output logic                   rd_en,
  output logic [ADDR_WIDTH-1:0]  rd_addr,
  input  logic [DATA_WIDTH-1:0]  rd_data,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [DATA_WIDTH-1:0]  res_value,
  output logic [INDEX_WIDTH-1:0] res_index,
  output logic [ROW_WIDTH-1:0]   res_row
);

  typedef enum logic [2:0] {S_IDLE, S_READ, S_DRAIN, S_EMIT, S_DONE} state_t;

  state_t                 r_state, w_state_nxt;
  logic [ROW_WIDTH-1:0]   r_num_rows, r_row;
  logic [INDEX_WIDTH-1:0] r_row_len, r_col, r_cmp_col, r_max_idx, w_idx_nxt;
  logic [DATA_WIDTH-1:0]  r_max, w_max_nxt;
  logic                   r_cmp_vld, w_take, w_last_col, w_last_row;
  logic                   r_busy, r_done, r_rd_en, r_res_valid;
  logic [ADDR_WIDTH-1:0]  r_rd_addr;
  logic [DATA_WIDTH-1:0]  r_res_value;
  logic [INDEX_WIDTH-1:0] r_res_index;
  logic [ROW_WIDTH-1:0]   r_res_row;

  // Raw-bit fp16 ordering: sign first (-0 < +0), magnitude reversed for negatives.
  function automatic logic fp16_gt(input logic [DATA_WIDTH-1:0] a, input logic [DATA_WIDTH-1:0] b);
    if (a[DATA_WIDTH-1] != b[DATA_WIDTH-1]) return b[DATA_WIDTH-1];
    if (!a[DATA_WIDTH-1]) return a[DATA_WIDTH-2:0] > b[DATA_WIDTH-2:0];
    return a[DATA_WIDTH-2:0] < b[DATA_WIDTH-2:0];
  endfunction

  always_comb begin
    w_take      = 1'b0;
    w_max_nxt   = r_max;
    w_idx_nxt   = r_max_idx;
    w_last_col  = (r_col == r_row_len - INDEX_WIDTH'(1));
    w_last_row  = (r_row == r_num_rows - ROW_WIDTH'(1));
    w_state_nxt = r_state;
    if (r_cmp_vld && ((r_cmp_col == '0) || fp16_gt(rd_data, r_max))) begin
      w_take    = 1'b1;
      w_max_nxt = rd_data;
      w_idx_nxt = r_cmp_col;
    end
    case (r_state)
      S_IDLE: begin
        if (start) begin
          if ((cfg_num_rows == '0) || (cfg_row_len == '0)) w_state_nxt = S_DONE;
          else                                             w_state_nxt = S_READ;
        end
      end
      S_READ:  if (w_last_col) w_state_nxt = S_DRAIN;
      S_DRAIN: w_state_nxt = S_EMIT;
      S_EMIT: begin
        if (res_ready) w_state_nxt = w_last_row ? S_DONE : S_READ;
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_num_rows  <= '0;
      r_row_len   <= '0;
      r_row       <= '0;
      r_col       <= '0;
      r_cmp_vld   <= 1'b0;
      r_cmp_col   <= '0;
      r_max       <= '0;
      r_max_idx   <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_rd_en     <= 1'b0;
      r_rd_addr   <= '0;
      r_res_valid <= 1'b0;
      r_res_value <= '0;
      r_res_index <= '0;
      r_res_row   <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_cmp_vld   <= r_rd_en;
      r_cmp_col   <= r_col;
      r_max       <= w_max_nxt;
      r_max_idx   <= w_idx_nxt;
      r_busy      <= (w_state_nxt != S_IDLE);
      r_done      <= (w_state_nxt == S_DONE);
      r_rd_en     <= (w_state_nxt == S_READ);
      r_res_valid <= (w_state_nxt == S_EMIT);
      // Read pointer runs continuously across rows; it holds on the last issued address.
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_num_rows <= cfg_num_rows;
            r_row_len  <= cfg_row_len;
            r_row      <= '0;
            r_col      <= '0;
            r_rd_addr  <= cfg_base_addr;
          end
        end
        S_READ: begin
          if (!w_last_col) begin
            r_col     <= r_col + INDEX_WIDTH'(1);
            r_rd_addr <= r_rd_addr + ADDR_WIDTH'(1);
          end
        end
        S_DRAIN: begin
          r_res_value <= w_max_nxt;
          r_res_index <= w_idx_nxt;
          r_res_row   <= r_row;
        end
        S_EMIT: begin
          if (res_ready && !w_last_row) begin
            r_row     <= r_row + ROW_WIDTH'(1);
            r_col     <= '0;
            r_rd_addr <= r_rd_addr + ADDR_WIDTH'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign busy      = r_busy;
  assign done      = r_done;
  assign rd_en     = r_rd_en;
  assign rd_addr   = r_rd_addr;
  assign res_valid = r_res_valid;
  assign res_value = r_res_value;
  assign res_index = r_res_index;
  assign res_row   = r_res_row;

endmodule

// File: tb/tb_argmax_row_ctrl.sv
// Directed bench for argmax_row_ctrl: SRAM model plus cycle-exact checks of reads,
// results, handshake stalls, empty jobs and mid-run reset.
module tb_argmax_row_ctrl;

  logic        clk = 1'b0;
  logic        rst, start, res_ready;
  logic [15:0] cfg_base_addr, cfg_num_rows, cfg_row_len;
  logic        busy, done, rd_en, res_valid;
  logic [15:0] rd_addr, rd_data, res_value, res_index, res_row;

  logic [15:0] mem [0:65535];
  logic [15:0] exp_val [0:3];
  logic [15:0] exp_idx [0:3];
  int n_cmp = 0;
  int n_err = 0;

  argmax_row_ctrl dut (
    .clk(clk), .rst(rst), .start(start),
    .cfg_base_addr(cfg_base_addr), .cfg_num_rows(cfg_num_rows), .cfg_row_len(cfg_row_len),
    .busy(busy), .done(done), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_value(res_value), .res_index(res_index), .res_row(res_row)
  );

  always #5 clk = ~clk;

  // Single-port SRAM, one cycle read latency
  always @(posedge clk) if (rd_en) rd_data <= mem[rd_addr];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle_zero(input string tag);
    check_eq({tag, " busy"},  32'(busy), 0);
    check_eq({tag, " done"},  32'(done), 0);
    check_eq({tag, " rd_en"}, 32'(rd_en), 0);
    check_eq({tag, " addr"},  32'(rd_addr), 0);
    check_eq({tag, " valid"}, 32'(res_valid), 0);
    check_eq({tag, " value"}, 32'(res_value), 0);
    check_eq({tag, " index"}, 32'(res_index), 0);
    check_eq({tag, " row"},   32'(res_row), 0);
  endtask

  // Full job with res_ready=1 except a stall on row 0; start is held one extra
  // cycle with scrambled cfg to prove both are ignored while busy.
  task automatic run_job(input string tag, input logic [15:0] base, input int nrows,
                         input int len, input int stall);
    logic [15:0] a;
    cfg_base_addr = base;
    cfg_num_rows  = 16'(nrows);
    cfg_row_len   = 16'(len);
    res_ready     = 1'b1;
    start         = 1'b1;
    tick();
    cfg_base_addr = 16'hDEAD;
    cfg_num_rows  = 16'd7;
    cfg_row_len   = 16'd9;
    for (int r = 0; r < nrows; r++) begin
      for (int c = 0; c < len; c++) begin
        a = 16'(int'(base) + r * len + c);
        check_eq($sformatf("%s r%0d c%0d rd_en", tag, r, c), 32'(rd_en), 1);
        check_eq($sformatf("%s r%0d c%0d addr", tag, r, c), 32'(rd_addr), 32'(a));
        check_eq($sformatf("%s r%0d c%0d valid", tag, r, c), 32'(res_valid), 0);
        tick();
        start = 1'b0;
      end
      check_eq($sformatf("%s r%0d drain rd_en", tag, r), 32'(rd_en), 0);
      check_eq($sformatf("%s r%0d drain valid", tag, r), 32'(res_valid), 0);
      if (r == 0 && stall > 0) res_ready = 1'b0;
      tick();
      for (int s = 0; s <= ((r == 0) ? stall : 0); s++) begin
        if (r == 0 && s == stall) res_ready = 1'b1;
        check_eq($sformatf("%s r%0d s%0d valid", tag, r, s), 32'(res_valid), 1);
        check_eq($sformatf("%s r%0d s%0d value", tag, r, s), 32'(res_value), 32'(exp_val[r]));
        check_eq($sformatf("%s r%0d s%0d index", tag, r, s), 32'(res_index), 32'(exp_idx[r]));
        check_eq($sformatf("%s r%0d s%0d row", tag, r, s), 32'(res_row), 32'(r));
        check_eq($sformatf("%s r%0d s%0d rd_en", tag, r, s), 32'(rd_en), 0);
        check_eq($sformatf("%s r%0d s%0d done", tag, r, s), 32'(done), 0);
        tick();
      end
    end
    check_eq({tag, " done pulse"}, 32'(done), 1);
    check_eq({tag, " busy in done"}, 32'(busy), 1);
    check_eq({tag, " valid in done"}, 32'(res_valid), 0);
    check_eq({tag, " rd_en in done"}, 32'(rd_en), 0);
    tick();
    check_eq({tag, " done low"}, 32'(done), 0);
    check_eq({tag, " busy low"}, 32'(busy), 0);
  endtask

  // Zero rows or zero length: straight to DONE; start held through DONE must not relaunch.
  task automatic run_empty(input string tag, input int nrows, input int len);
    cfg_base_addr = 16'h0040;
    cfg_num_rows  = 16'(nrows);
    cfg_row_len   = 16'(len);
    start         = 1'b1;
    tick();
    check_eq({tag, " done"},  32'(done), 1);
    check_eq({tag, " busy"},  32'(busy), 1);
    check_eq({tag, " rd_en"}, 32'(rd_en), 0);
    check_eq({tag, " valid"}, 32'(res_valid), 0);
    tick();
    start = 1'b0;
    check_eq({tag, " done low"}, 32'(done), 0);
    check_eq({tag, " busy low"}, 32'(busy), 0);
    tick();
    check_eq({tag, " still idle"}, 32'(busy), 0);
    check_eq({tag, " no read"}, 32'(rd_en), 0);
    check_eq({tag, " no done"}, 32'(done), 0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; res_ready = 1'b1;
    cfg_base_addr = '0; cfg_num_rows = '0; cfg_row_len = '0;
    for (int i = 0; i < 65536; i++) mem[i] = 16'h0000;
    mem[16'h0000] = 16'h3C00; mem[16'h0001] = 16'h4000;
    mem[16'h0002] = 16'h4000; mem[16'h0003] = 16'hC000;
    mem[16'h0010] = 16'hC000; mem[16'h0011] = 16'hBC00; mem[16'h0012] = 16'hC200;
    mem[16'h0020] = 16'h8000; mem[16'h0021] = 16'h0000;
    mem[16'h0100] = 16'h0001; mem[16'h0101] = 16'h0005; mem[16'h0102] = 16'h0003; mem[16'h0103] = 16'h0005;
    mem[16'h0104] = 16'h8001; mem[16'h0105] = 16'h8000; mem[16'h0106] = 16'hFC00; mem[16'h0107] = 16'h8002;
    mem[16'h0108] = 16'h0000; mem[16'h0109] = 16'h3C00; mem[16'h010A] = 16'h3C00; mem[16'h010B] = 16'h7C00;
    mem[16'h0200] = 16'h1234; mem[16'h0201] = 16'h1234; mem[16'h0202] = 16'h0000; mem[16'h0203] = 16'h8000;
    mem[16'h0204] = 16'h8000; mem[16'h0205] = 16'h8000; mem[16'h0206] = 16'h0001; mem[16'h0207] = 16'h0000;
    mem[16'h0300] = 16'h0100; mem[16'h0301] = 16'h0200; mem[16'h0302] = 16'h0300; mem[16'h0303] = 16'h0050;
    mem[16'hFFFE] = 16'hBC00; mem[16'hFFFF] = 16'hC000;
    tick(); tick();
    rst = 1'b0;
    check_idle_zero("reset");

    exp_val[0] = 16'h4000; exp_idx[0] = 16'd1;
    run_job("basic", 16'h0000, 1, 4, 0);
    exp_val[0] = 16'hBC00; exp_idx[0] = 16'd1;
    run_job("neg", 16'h0010, 1, 3, 0);
    exp_val[0] = 16'h0000; exp_idx[0] = 16'd1;
    run_job("zero sign", 16'h0020, 1, 2, 0);
    exp_val[0] = 16'h0005; exp_idx[0] = 16'd1;
    exp_val[1] = 16'h8000; exp_idx[1] = 16'd1;
    exp_val[2] = 16'h7C00; exp_idx[2] = 16'd3;
    run_job("multi", 16'h0100, 3, 4, 0);
    exp_val[0] = 16'h1234; exp_idx[0] = 16'd0;
    exp_val[1] = 16'h0001; exp_idx[1] = 16'd2;
    run_job("stall", 16'h0200, 2, 4, 5);
    exp_val[0] = 16'h4000; exp_idx[0] = 16'd3;
    run_job("wrap", 16'hFFFE, 1, 4, 0);
    run_empty("rows0", 0, 4);
    run_empty("len0", 3, 0);

    cfg_base_addr = 16'h0300; cfg_num_rows = 16'd1; cfg_row_len = 16'd4;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_idle_zero("midreset");
    tick();
    check_idle_zero("midreset+1");
    exp_val[0] = 16'h0300; exp_idx[0] = 16'd2;
    run_job("after reset", 16'h0300, 1, 4, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/argmax_row_ctrl.md
Name: argmax_row_ctrl

Overview:
- Sequences row-wise fp16 argmax over a matrix held in a single-port SRAM with 1-cycle read latency.
- On `start`, walks `cfg_num_rows` rows of `cfg_row_len` elements from `cfg_base_addr`, tracks the running maximum and its column index, and emits one result per row over a valid/ready channel.
- Used by the attention/top-1 path to produce per-row max scores and positions.

Parameters:
- ADDR_WIDTH, 16, SRAM word address width.
- INDEX_WIDTH, 16, column index / row length width.
- ROW_WIDTH, 16, row counter width.
- DATA_WIDTH, 16, element width; fp16 only, fixed at 16.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- start  in  1  one-cycle launch; sampled only in IDLE.
- cfg_base_addr  in  ADDR_WIDTH  address of row 0, column 0.
- cfg_num_rows  in  ROW_WIDTH  number of rows.
- cfg_row_len  in  INDEX_WIDTH  elements per row.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse after the last result is accepted.
- rd_en  out  1  SRAM read strobe.
- rd_addr  out  ADDR_WIDTH  SRAM read address.
- rd_data  in  DATA_WIDTH  SRAM data, valid exactly 1 cycle after rd_en.
- res_valid  out  1  result valid.
- res_ready  in  1  result accepted when res_valid && res_ready.
- res_value  out  DATA_WIDTH  row max (fp16 bits).
- res_index  out  INDEX_WIDTH  column of row max.
- res_row  out  ROW_WIDTH  row number of this result.

Behaviour:
- Reset (synchronous; on the next edge with rst=1, including mid-operation):
  - State goes to IDLE.
  - All outputs 0 and all counters cleared.
  - Any in-flight read data is discarded.
- States and transitions:
  - IDLE -> READ on start.
  - READ -> DRAIN after the last column read is issued.
  - DRAIN -> EMIT.
  - EMIT -> READ when handshake completes and rows remain.
  - EMIT -> DONE when handshake completes on the last row.
  - DONE -> IDLE.
- Start: cfg_* latched on the start cycle. If cfg_num_rows==0 or cfg_row_len==0, go IDLE->DONE: no reads, no results, done pulses.
- Start is ignored while busy.
- READ:
  - rd_en=1 every cycle, col 0..L-1.
  - rd_addr is a running pointer: starts at cfg_base_addr and increments by 1 per read, continuous across rows (row r col c = base + r*L + c), wrapping modulo 2^ADDR_WIDTH.
- Compare, applied on the cycle after each read (READ and DRAIN):
  - Returned element at column c replaces the running max if c==0 or (element > running max). Strict, so ties keep the earliest index.
  - fp16 order is on raw bits:
    - sign first; -x < +y; -0 (0x8000) < +0 (0x0000).
    - Both positive: larger {exp,frac} wins.
    - Both negative: smaller {exp,frac} wins.
    - NaN/Inf are not special-cased.
- Timing, start sampled at cycle 0:
  - READ covers cycles 1..L.
  - DRAIN at L+1.
  - res_valid=1 from cycle L+2.
  - With res_ready=1, the next row's first rd_en is at L+3.
  - Per-row period: L+2 cycles.
- EMIT:
  - res_valid held until accepted.
  - res_value/res_index/res_row stable while res_valid && !res_ready.
  - rd_en=0 throughout EMIT (no prefetch).
  - res_valid drops the cycle after acceptance.
- done: one-cycle pulse in DONE, the cycle after the last acceptance. busy falls in the same cycle done falls.
- Outside EMIT, res_valid=0. res_value/res_index/res_row hold their last values.

Test Plan:
- L=4, 1 row, base 0, data 0x3C00,0x4000,0x4000,0xC000, ready=1 -> rd_addr 0..3 on cycles 1-4; res_valid at cycle 6; value 0x4000, index 1, row 0; done at cycle 7.
- L=3, data 0xC000,0xBC00,0xC200 -> value 0xBC00, index 1. L=2, data 0x8000,0x0000 -> value 0x0000, index 1.
- base 0x100, 3 rows, L=4, ready=1 -> rd_addr 0x100..0x10B contiguous; results for rows 0,1,2 with 6-cycle spacing; single done after the third acceptance.
- Backpressure: res_ready=0 for 5 cycles at the first EMIT -> res_valid and outputs held stable, rd_en=0; row 1 reads start the cycle after acceptance.
- cfg_num_rows=0 or cfg_row_len=0 -> no rd_en, no res_valid, done pulses once; a second start while busy is ignored.
- rst=1 at cycle 2 of a 4-element row -> next cycle IDLE, all outputs 0; a new start runs cleanly from cfg_base_addr.
